// File: rtl/reg_scoreboard_if.sv
// Issue/writeback-side bundle of the register hazard scoreboard.
// The master drives marks, releases, flush and source checks. The slave returns readiness, hazards and status.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int NUM_MARK = 2,
  parameter int NUM_REL  = 2,
  parameter int NUM_RD   = 2
);
  localparam int SEL_W = $clog2(NUM_REGS);

  // Handshake: a mark port j is taken on a rising edge when MARK_VALID[j] && MARK_READY[j].
  // MARK_READY is combinational from the registered counters, so the issuer holds a refused
  // mark until it sees ready. Releases, flush and read checks are fire-and-forget with no ready.
  logic [NUM_MARK-1:0]       MARK_VALID;
  logic [NUM_MARK*SEL_W-1:0] MARK_SEL;
  logic [NUM_MARK-1:0]       MARK_READY;
  logic [NUM_REL-1:0]        REL_VALID;
  logic [NUM_REL*SEL_W-1:0]  REL_SEL;
  logic                      FLUSH;
  logic [NUM_RD*SEL_W-1:0]   RD_SEL;
  logic [NUM_RD-1:0]         RD_VALID;
  logic [NUM_RD-1:0]         RD_HAZARD;
  logic                      ANY_HAZARD;
  logic [NUM_REGS-1:0]       BUSY;
  logic                      REL_ERR;

  modport master (
    output MARK_VALID, MARK_SEL, REL_VALID, REL_SEL, FLUSH, RD_SEL, RD_VALID,
    input  MARK_READY, RD_HAZARD, ANY_HAZARD, BUSY, REL_ERR
  );

  modport slave (
    input  MARK_VALID, MARK_SEL, REL_VALID, REL_SEL, FLUSH, RD_SEL, RD_VALID,
    output MARK_READY, RD_HAZARD, ANY_HAZARD, BUSY, REL_ERR
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard with per-register outstanding-write counters.
// Decode marks destinations and checks sources. Writeback releases entries. Flush clears everything.
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int NUM_MARK = 2,
  parameter int NUM_REL  = 2,
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2
) (
  input logic        CLK,
  input logic        RESET,
  reg_scoreboard_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REGS);
  // Wide enough to hold cnt plus every port's contribution without wrapping.
  localparam int ACC_W = CNT_W + $clog2(NUM_MARK + NUM_REL + 1) + 1;
  localparam logic [ACC_W-1:0] CNT_MAX_W = ACC_W'((1 << CNT_W) - 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [ACC_W-1:0] acc_t;

  cnt_t cnt     [NUM_REGS];
  cnt_t cnt_nxt [NUM_REGS];
  acc_t add_cnt [NUM_REGS];
  acc_t sub_cnt [NUM_REGS];
  acc_t nxt_wide[NUM_REGS];
  logic rel_err_q;

  logic [SEL_W-1:0] mark_sel[NUM_MARK];
  logic [SEL_W-1:0] rel_sel [NUM_REL];
  logic [SEL_W-1:0] rd_sel  [NUM_RD];

  logic [NUM_MARK-1:0] mark_ready;
  logic [NUM_MARK-1:0] mark_acc;
  logic [NUM_REL-1:0]  rel_legal;
  logic [NUM_REL-1:0]  rel_ill;
  logic [NUM_RD-1:0]   rd_hazard;
  logic [NUM_REGS-1:0] busy;

  always_comb begin : unpack_sel
    for (int j = 0; j < NUM_MARK; j++) mark_sel[j] = bus.MARK_SEL[j*SEL_W +: SEL_W];
    for (int i = 0; i < NUM_REL; i++)  rel_sel[i]  = bus.REL_SEL[i*SEL_W +: SEL_W];
    for (int i = 0; i < NUM_RD; i++)   rd_sel[i]   = bus.RD_SEL[i*SEL_W +: SEL_W];
  end

  // Lower-index ports get first claim on the remaining headroom of a counter.
  always_comb begin : mark_arb
    acc_t k;
    mark_ready = '0;
    mark_acc   = '0;
    k          = '0;
    for (int j = 0; j < NUM_MARK; j++) begin
      k = '0;
      for (int p = 0; p < j; p++) begin
        if (mark_acc[p] && (mark_sel[p] == mark_sel[j])) k = k + ACC_W'(1);
      end
      mark_ready[j] = (ACC_W'(cnt[mark_sel[j]]) + k) < CNT_MAX_W;
      mark_acc[j]   = bus.MARK_VALID[j] && mark_ready[j];
    end
  end

  // Releases only consume what is already outstanding; same-cycle marks do not count.
  always_comb begin : rel_check
    acc_t d;
    rel_legal = '0;
    rel_ill   = '0;
    d         = '0;
    for (int i = 0; i < NUM_REL; i++) begin
      d = '0;
      for (int p = 0; p < i; p++) begin
        if (rel_legal[p] && (rel_sel[p] == rel_sel[i])) d = d + ACC_W'(1);
      end
      if (bus.REL_VALID[i]) begin
        if (ACC_W'(cnt[rel_sel[i]]) > d) rel_legal[i] = 1'b1;
        else                             rel_ill[i]   = 1'b1;
      end
    end
  end

  always_comb begin : per_reg_next
    for (int r = 0; r < NUM_REGS; r++) begin
      add_cnt[r] = '0;
      sub_cnt[r] = '0;
      for (int j = 0; j < NUM_MARK; j++) begin
        if (mark_acc[j] && (mark_sel[j] == SEL_W'(r))) add_cnt[r] = add_cnt[r] + ACC_W'(1);
      end
      for (int i = 0; i < NUM_REL; i++) begin
        if (rel_legal[i] && (rel_sel[i] == SEL_W'(r))) sub_cnt[r] = sub_cnt[r] + ACC_W'(1);
      end
      nxt_wide[r] = ACC_W'(cnt[r]) + add_cnt[r] - sub_cnt[r];
      cnt_nxt[r]  = nxt_wide[r][CNT_W-1:0];
    end
  end

  // Flush behaves like reset on the tracking state; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET || bus.FLUSH) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      rel_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      rel_err_q <= |rel_ill;
    end
  end

  always_comb begin : status
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
    for (int i = 0; i < NUM_RD; i++)   rd_hazard[i] = bus.RD_VALID[i] && (cnt[rd_sel[i]] != '0);
  end

  assign bus.MARK_READY = mark_ready;
  assign bus.RD_HAZARD  = rd_hazard;
  assign bus.ANY_HAZARD = |rd_hazard;
  assign bus.BUSY       = busy;
  assign bus.REL_ERR    = rel_err_q;

  // Counters must stay within 0..CNT_MAX on every committed update.
  always_ff @(posedge CLK) begin
    if (!RESET && !bus.FLUSH) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        assert ((ACC_W'(cnt[r]) + add_cnt[r]) >= sub_cnt[r]);
        assert (nxt_wide[r] <= CNT_MAX_W);
      end
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register counting model.
module tb_reg_scoreboard;
  localparam int NUM_REGS = 8;
  localparam int NUM_MARK = 2;
  localparam int NUM_REL  = 2;
  localparam int NUM_RD   = 2;
  localparam int CNT_W    = 2;
  localparam int SEL_W    = 3;
  localparam int CNT_MAX  = 3;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_MARK(NUM_MARK), .NUM_REL(NUM_REL),
                      .NUM_RD(NUM_RD)) bus ();

  reg_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_MARK(NUM_MARK), .NUM_REL(NUM_REL),
                   .NUM_RD(NUM_RD), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  int n_vec;
  int n_miss;

  // Reference state: outstanding writes per register and the pending error pulse.
  int   m_cnt  [NUM_REGS];
  int   nxt_cnt[NUM_REGS];
  bit   m_err;
  bit   nxt_err;
  logic [NUM_MARK-1:0] exp_ready;
  logic [NUM_RD-1:0]   exp_haz;
  logic                exp_any;
  logic [NUM_REGS-1:0] exp_busy;

  task automatic clear_inputs();
    bus.MARK_VALID = '0;
    bus.MARK_SEL   = '0;
    bus.REL_VALID  = '0;
    bus.REL_SEL    = '0;
    bus.FLUSH      = 1'b0;
    bus.RD_SEL     = '0;
    bus.RD_VALID   = '0;
  endtask

  task automatic set_mark(input int j, input logic v, input int r);
    bus.MARK_VALID[j] = v;
    bus.MARK_SEL[j*SEL_W +: SEL_W] = SEL_W'(r);
  endtask

  task automatic set_rel(input int i, input logic v, input int r);
    bus.REL_VALID[i] = v;
    bus.REL_SEL[i*SEL_W +: SEL_W] = SEL_W'(r);
  endtask

  task automatic set_rd(input int i, input logic v, input int r);
    bus.RD_VALID[i] = v;
    bus.RD_SEL[i*SEL_W +: SEL_W] = SEL_W'(r);
  endtask

  // Marks fill a register's headroom in port order; releases drain what is already outstanding.
  function automatic void model_eval();
    int pending[NUM_REGS];
    int avail[NUM_REGS];
    int s;
    bit ill;
    ill = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = m_cnt[r];
      avail[r]   = m_cnt[r];
    end
    for (int j = 0; j < NUM_MARK; j++) begin
      s = int'(bus.MARK_SEL[j*SEL_W +: SEL_W]);
      exp_ready[j] = (pending[s] < CNT_MAX);
      if (bus.MARK_VALID[j] && exp_ready[j]) pending[s]++;
    end
    for (int i = 0; i < NUM_REL; i++) begin
      s = int'(bus.REL_SEL[i*SEL_W +: SEL_W]);
      if (bus.REL_VALID[i]) begin
        if (avail[s] > 0) avail[s]--;
        else              ill = 1'b1;
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      s = int'(bus.RD_SEL[i*SEL_W +: SEL_W]);
      exp_haz[i] = bus.RD_VALID[i] && (m_cnt[s] > 0);
    end
    exp_any = |exp_haz;
    for (int r = 0; r < NUM_REGS; r++) exp_busy[r] = (m_cnt[r] > 0);
    for (int r = 0; r < NUM_REGS; r++) begin
      if (RESET || bus.FLUSH) nxt_cnt[r] = 0;
      else nxt_cnt[r] = m_cnt[r] + (pending[r] - m_cnt[r]) - (m_cnt[r] - avail[r]);
    end
    nxt_err = !(RESET || bus.FLUSH) && ill;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge CLK);
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = nxt_cnt[r];
    m_err = nxt_err;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    clear_inputs();
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (bus.BUSY !== 8'h00) begin n_miss++; $display("FAIL reset_busy: got %h want 00", bus.BUSY); end
    n_vec++;
    if (bus.RD_HAZARD !== 2'b00) begin n_miss++; $display("FAIL reset_hazard: got %b want 00", bus.RD_HAZARD); end
    n_vec++;
    if (bus.REL_ERR !== 1'b0) begin n_miss++; $display("FAIL reset_relerr: got %b want 0", bus.REL_ERR); end
    n_vec++;
    if (bus.MARK_READY !== 2'b11) begin n_miss++; $display("FAIL reset_ready: got %b want 11", bus.MARK_READY); end
    tick();
  endtask

  task automatic test_mark_check();
    set_mark(0, 1'b1, 3);
    set_rd(0, 1'b1, 3);
    @(negedge CLK);
    n_vec++;
    if (bus.RD_HAZARD[0] !== 1'b0) begin n_miss++; $display("FAIL mark_no_forward: got %b want 0", bus.RD_HAZARD[0]); end
    tick();
    set_mark(0, 1'b0, 0);
    @(negedge CLK);
    n_vec++;
    if (bus.RD_HAZARD[0] !== 1'b1) begin n_miss++; $display("FAIL mark_hazard: got %b want 1", bus.RD_HAZARD[0]); end
    n_vec++;
    if (bus.BUSY !== 8'h08) begin n_miss++; $display("FAIL mark_busy: got %h want 08", bus.BUSY); end
    n_vec++;
    if (bus.ANY_HAZARD !== 1'b1) begin n_miss++; $display("FAIL mark_any: got %b want 1", bus.ANY_HAZARD); end
    set_rel(0, 1'b1, 3);
    tick();
    clear_inputs();
    @(negedge CLK);
    n_vec++;
    if (bus.BUSY !== 8'h00) begin n_miss++; $display("FAIL mark_release_busy: got %h want 00", bus.BUSY); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 3; n++) begin
      set_mark(0, 1'b1, 5);
      tick();
    end
    set_mark(0, 1'b1, 5);
    set_mark(1, 1'b1, 5);
    @(negedge CLK);
    n_vec++;
    if (bus.MARK_READY !== 2'b00) begin n_miss++; $display("FAIL sat_ready: got %b want 00", bus.MARK_READY); end
    tick();
    clear_inputs();
    for (int n = 0; n < 3; n++) begin
      set_rel(0, 1'b1, 5);
      tick();
      clear_inputs();
      @(negedge CLK);
      n_vec++;
      if (bus.BUSY[5] !== (n < 2)) begin
        n_miss++; $display("FAIL sat_release%0d: busy5 got %b want %b", n, bus.BUSY[5], (n < 2));
      end
      n_vec++;
      if (bus.REL_ERR !== 1'b0) begin n_miss++; $display("FAIL sat_relerr%0d: got %b want 0", n, bus.REL_ERR); end
    end
  endtask

  task automatic test_collision();
    for (int n = 0; n < 2; n++) begin
      set_mark(0, 1'b1, 2);
      tick();
    end
    set_mark(0, 1'b1, 2);
    set_mark(1, 1'b1, 2);
    @(negedge CLK);
    n_vec++;
    if (bus.MARK_READY !== 2'b01) begin n_miss++; $display("FAIL coll_ready: got %b want 01", bus.MARK_READY); end
    tick();
    clear_inputs();
    set_mark(1, 1'b1, 2);
    @(negedge CLK);
    n_vec++;
    if (bus.MARK_READY[1] !== 1'b0) begin n_miss++; $display("FAIL coll_full: got %b want 0", bus.MARK_READY[1]); end
    clear_inputs();
    bus.FLUSH = 1'b1;
    tick();
    clear_inputs();
    @(negedge CLK);
    n_vec++;
    if (bus.BUSY !== 8'h00) begin n_miss++; $display("FAIL coll_flush: got %h want 00", bus.BUSY); end
  endtask

  task automatic test_mark_release();
    set_mark(0, 1'b1, 1);
    tick();
    set_mark(0, 1'b1, 1);
    set_rel(0, 1'b1, 1);
    set_rd(0, 1'b1, 1);
    @(negedge CLK);
    n_vec++;
    if (bus.RD_HAZARD[0] !== 1'b1) begin n_miss++; $display("FAIL mr_hazard_now: got %b want 1", bus.RD_HAZARD[0]); end
    tick();
    set_mark(0, 1'b0, 0);
    set_rel(0, 1'b0, 0);
    @(negedge CLK);
    n_vec++;
    if (bus.RD_HAZARD[0] !== 1'b1) begin n_miss++; $display("FAIL mr_hazard_next: got %b want 1", bus.RD_HAZARD[0]); end
    n_vec++;
    if (bus.BUSY !== 8'h02) begin n_miss++; $display("FAIL mr_busy: got %h want 02", bus.BUSY); end
    set_rel(0, 1'b1, 6);
    tick();
    set_rel(0, 1'b0, 0);
    @(negedge CLK);
    n_vec++;
    if (bus.REL_ERR !== 1'b1) begin n_miss++; $display("FAIL underflow_err: got %b want 1", bus.REL_ERR); end
    n_vec++;
    if (bus.BUSY !== 8'h02) begin n_miss++; $display("FAIL underflow_busy: got %h want 02", bus.BUSY); end
    tick();
    @(negedge CLK);
    n_vec++;
    if (bus.REL_ERR !== 1'b0) begin n_miss++; $display("FAIL underflow_pulse: got %b want 0", bus.REL_ERR); end
    // Two releases of a register holding one outstanding write: the second is illegal.
    set_rel(0, 1'b1, 1);
    set_rel(1, 1'b1, 1);
    tick();
    clear_inputs();
    @(negedge CLK);
    n_vec++;
    if (bus.BUSY !== 8'h00) begin n_miss++; $display("FAIL dual_rel_busy: got %h want 00", bus.BUSY); end
    n_vec++;
    if (bus.REL_ERR !== 1'b1) begin n_miss++; $display("FAIL dual_rel_err: got %b want 1", bus.REL_ERR); end
    tick();
  endtask

  task automatic test_flush();
    set_mark(0, 1'b1, 0);
    set_mark(1, 1'b1, 4);
    tick();
    clear_inputs();
    bus.FLUSH = 1'b1;
    set_mark(0, 1'b1, 7);
    set_rd(0, 1'b1, 7);
    set_rd(1, 1'b1, 0);
    @(negedge CLK);
    n_vec++;
    if (bus.MARK_READY[0] !== 1'b1) begin n_miss++; $display("FAIL flush_ready: got %b want 1", bus.MARK_READY[0]); end
    n_vec++;
    if (bus.RD_HAZARD !== 2'b10) begin n_miss++; $display("FAIL flush_pre_haz: got %b want 10", bus.RD_HAZARD); end
    tick();
    bus.FLUSH = 1'b0;
    set_mark(0, 1'b0, 0);
    @(negedge CLK);
    n_vec++;
    if (bus.BUSY !== 8'h00) begin n_miss++; $display("FAIL flush_busy: got %h want 00", bus.BUSY); end
    n_vec++;
    if (bus.RD_HAZARD !== 2'b00) begin n_miss++; $display("FAIL flush_haz: got %b want 00", bus.RD_HAZARD); end
    n_vec++;
    if (bus.ANY_HAZARD !== 1'b0) begin n_miss++; $display("FAIL flush_any: got %b want 0", bus.ANY_HAZARD); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_override();
    set_mark(0, 1'b1, 3);
    set_mark(1, 1'b1, 6);
    tick();
    RESET = 1'b1;
    bus.FLUSH = 1'b1;
    set_rel(0, 1'b1, 0);
    tick();
    RESET = 1'b0;
    clear_inputs();
    @(negedge CLK);
    n_vec++;
    if (bus.BUSY !== 8'h00) begin n_miss++; $display("FAIL rst_override_busy: got %h want 00", bus.BUSY); end
    n_vec++;
    if (bus.REL_ERR !== 1'b0) begin n_miss++; $display("FAIL rst_override_err: got %b want 0", bus.REL_ERR); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < NUM_MARK; j++) set_mark(j, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      for (int i = 0; i < NUM_REL; i++)  set_rel(i, 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
      for (int i = 0; i < NUM_RD; i++)   set_rd(i, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
      bus.FLUSH = ($urandom_range(0, 24) == 0);
      RESET     = ($urandom_range(0, 59) == 0);
      @(negedge CLK);
      model_eval();
      n_vec++;
      if (bus.MARK_READY !== exp_ready) begin
        n_miss++; $display("FAIL rand_ready c=%0d: got %b want %b", c, bus.MARK_READY, exp_ready);
      end
      n_vec++;
      if (bus.RD_HAZARD !== exp_haz) begin
        n_miss++; $display("FAIL rand_hazard c=%0d: got %b want %b", c, bus.RD_HAZARD, exp_haz);
      end
      n_vec++;
      if (bus.ANY_HAZARD !== exp_any) begin
        n_miss++; $display("FAIL rand_any c=%0d: got %b want %b", c, bus.ANY_HAZARD, exp_any);
      end
      n_vec++;
      if (bus.BUSY !== exp_busy) begin
        n_miss++; $display("FAIL rand_busy c=%0d: got %h want %h", c, bus.BUSY, exp_busy);
      end
      n_vec++;
      if (bus.REL_ERR !== m_err) begin
        n_miss++; $display("FAIL rand_relerr c=%0d: got %b want %b", c, bus.REL_ERR, m_err);
      end
      tick();
    end
    RESET = 1'b0;
    clear_inputs();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    m_err  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
    test_reset();
    test_mark_check();
    test_saturation();
    test_collision();
    test_mark_release();
    test_flush();
    test_reset_override();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
